// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO read-side stream stage.
// Buffer occupancy encoding and the stream beat bundle.
package fifo_stream_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_FRAME_LEN = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  last;
    } stream_beat_t;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry head/tail buffer with occupancy state machine.
// wr captures into the tail slot; rd retires the head.
import fifo_stream_pkg::*;

module stream_skid_buf2 #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    output logic [DATA_W-1:0] head,
    output occ_t              occ
);

    logic [DATA_W-1:0] tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ  <= EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            unique case (occ)
                EMPTY: begin
                    if (wr) begin
                        head <= wr_data;
                        occ  <= ONE;
                    end
                end
                ONE: begin
                    if (wr && rd) begin
                        head <= wr_data;
                    end else if (wr) begin
                        tail <= wr_data;
                        occ  <= TWO;
                    end else if (rd) begin
                        occ <= EMPTY;
                    end
                end
                TWO: begin
                    // a write without a read here would overflow; the issuer prevents it
                    if (rd) begin
                        head <= tail;
                        if (wr) begin
                            tail <= wr_data;
                        end else begin
                            occ <= ONE;
                        end
                    end
                end
                default: occ <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream with frame markers.
// Read issue keeps buffered plus in-flight words at most two.
import fifo_stream_pkg::*;

module fifo_stream_reader #(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int FCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [7:0]        beat_cnt,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [7:0] LAST_BEAT = 8'(FRAME_LEN - 1);

    occ_t       occ;
    logic       inflight;
    logic       pop;
    logic [1:0] level;

    stream_skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr      (inflight),
        .wr_data (fifo_dout),
        .rd      (pop),
        .head    (m_data),
        .occ     (occ)
    );

    assign m_valid = (occ != EMPTY);
    assign pop     = m_valid && m_ready;
    assign m_last  = m_valid && (beat_cnt == LAST_BEAT);

    // occupancy after this cycle's capture and pop; max 3 fits in 2 bits
    assign level      = 2'(occ) + 2'(inflight) - 2'(pop);
    assign fifo_rd_en = rst && !fifo_empty && (level < 2'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight  <= 1'b0;
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                beat_cnt <= m_last ? 8'd0 : beat_cnt + 8'd1;
            end
            if (pop && m_last) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    a_no_rd_empty: assert property (
        @(posedge clk) disable iff (!rst)
        !(fifo_rd_en && fifo_empty)
    );

    a_stall_stable: assert property (
        @(posedge clk) disable iff (!rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data))
    );

    a_occ_range: assert property (
        @(posedge clk) disable iff (!rst)
        (2'(occ) <= 2'd2) && !(occ == TWO && inflight && !pop)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench: FIFO model feeds the reader, a word-count
// reference model predicts valid, data, framing and read issue.
module tb_fifo_stream_reader;
    import fifo_stream_pkg::*;

    localparam int FL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout = 8'd0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_last;
    logic [7:0]  beat_cnt;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_W    (8),
        .FRAME_LEN (FL),
        .FCNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .beat_cnt   (beat_cnt),
        .frame_cnt  (frame_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         fetched = 0;
    int         xfer = 0;
    int         stall_left = 0;
    int         cyc = 0;
    logic       inflight_m = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] pend = 8'd0;
    logic [7:0] prev_data = 8'd0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_clear();
        fifo_q.delete();
        exp_q.delete();
        fetched    = 0;
        xfer       = 0;
        inflight_m = 1'b0;
        prev_stall = 1'b0;
        stall_left = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_en"}, fifo_rd_en, 0);
        check_eq({tag, "_valid"}, m_valid, 0);
        check_eq({tag, "_last"}, m_last, 0);
        check_eq({tag, "_data"}, m_data, 0);
        check_eq({tag, "_beat"}, beat_cnt, 0);
        check_eq({tag, "_frame"}, frame_cnt, 0);
    endtask

    // mode 0: stream, 1: backpressure, 2: empty toggling, 3: drain only
    task automatic step(input int mode);
        stream_beat_t got_b;
        stream_beat_t exp_b;
        logic         pop;
        logic         exp_rd;
        int           vis;
        logic         push;
        @(negedge clk);
        cyc++;
        fifo_dout = inflight_m ? pend : 8'($urandom);
        vis = fetched - int'(inflight_m);
        check_eq("m_valid", m_valid, vis > xfer);
        check_eq("beat_cnt", beat_cnt, xfer % FL);
        check_eq("frame_cnt", frame_cnt, (xfer / FL) % 65536);
        if (vis > xfer) begin
            exp_b.data = exp_q[0];
            exp_b.last = ((xfer % FL) == FL - 1);
            got_b.data = m_data;
            got_b.last = m_last;
            check_eq("beat", got_b, exp_b);
        end else begin
            check_eq("m_last_idle", m_last, 0);
        end
        if (prev_stall) check_eq("stall_hold", m_data, prev_data);
        inflight_m = 1'b0;
        rst = 1'b1;
        push = 1'b0;
        case (mode)
            0: begin
                m_ready = 1'b1;
                push = ($urandom % 8) != 0;
            end
            1: begin
                if (stall_left > 0) begin
                    m_ready = 1'b0;
                    stall_left--;
                end else if ($urandom % 10 == 0) begin
                    m_ready = 1'b0;
                    stall_left = 4;
                end else begin
                    m_ready = ($urandom % 4) != 0;
                end
                push = ($urandom % 4) != 0;
            end
            2: begin
                m_ready = ($urandom % 4) != 0;
                push = (cyc % 2) == 0;
            end
            default: begin
                m_ready = 1'b1;
            end
        endcase
        if (push && fifo_q.size() < 16) fifo_q.push_back(8'($urandom));
        fifo_empty = (fifo_q.size() == 0);
        #1;
        pop = m_valid && m_ready;
        exp_rd = !fifo_empty && ((fetched - xfer - int'(pop)) < 2);
        check_eq("rd_en", fifo_rd_en, exp_rd);
        if (fifo_rd_en && fifo_q.size() > 0) begin
            pend = fifo_q.pop_front();
            exp_q.push_back(pend);
            fetched++;
            inflight_m = 1'b1;
        end
        if (pop && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            xfer++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
    endtask

    initial begin
        bit reached;
        model_clear();
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_empty = 1'b0;
        m_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        // release happens inside the first step; rd_en must rise at once
        for (int i = 0; i < 300; i++) step(0);
        for (int i = 0; i < 400; i++) step(1);
        for (int i = 0; i < 300; i++) step(2);
        for (int i = 0; i < 20; i++) step(3);

        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            step(0);
            if (xfer % FL == 2 && m_valid) reached = 1'b1;
        end
        check_eq("midframe_reach", reached, 1);
        #2;
        rst = 1'b0;
        fifo_empty = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        model_clear();
        for (int i = 0; i < 200; i++) step(i % 3);

        for (int i = 0; i < 30; i++) step(3);
        fifo_q.push_back(8'hA5);
        for (int i = 0; i < 6; i++) step(3);
        check_eq("single_word_xfer", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
